// File: rtl/free_list_init_if.sv
// Push/pop handshake bundle for the banked free-list FIFO.
// Port-side names match the block's i__/o__ signal naming.
interface free_list_init_if #(
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned DATA_WIDTH = 16
);
  logic [NUM_BANKS-1:0]            i__data_in_valid;
  logic [NUM_BANKS*DATA_WIDTH-1:0] i__data_in;
  logic [NUM_BANKS-1:0]            o__data_in_ready;
  logic [NUM_BANKS-1:0]            o__data_out_valid;
  logic [NUM_BANKS*DATA_WIDTH-1:0] o__data_out;
  logic [NUM_BANKS-1:0]            i__data_out_ready;

  modport master (
    output i__data_in_valid, i__data_in, i__data_out_ready,
    input  o__data_in_ready, o__data_out_valid, o__data_out
  );

  modport slave (
    input  i__data_in_valid, i__data_in, i__data_out_ready,
    output o__data_in_ready, o__data_out_valid, o__data_out
  );
endinterface

// File: rtl/free_list_init.sv
// Banked FIFO free list that self-fills every bank after reset or reinit.
// Define FREE_LIST_INIT_OCCUPANCY_EN to expose per-bank counts on o__occupancy.
module free_list_init #(
  parameter int unsigned NUM_BANKS  = 2,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned INIT_VAL   = 0,
  parameter int unsigned INC_INIT   = 1
) (
  input  logic           w__init_clk,
  input  logic           reset,
  input  logic           i__reinit,
  free_list_init_if.slave bus,
  output logic           o__init_done
`ifdef FREE_LIST_INIT_OCCUPANCY_EN
  ,
  output logic [NUM_BANKS*$clog2(DEPTH+1)-1:0] o__occupancy
`endif
);

  localparam int unsigned ADDR_WIDTH = $clog2(DEPTH);
  localparam int unsigned CNT_WIDTH  = $clog2(DEPTH + 1);

  typedef enum logic {StInit, StReady} state_e;

  state_e                state_q;
  logic                  init_done_q;
  logic [ADDR_WIDTH-1:0] fill_cnt_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q [NUM_BANKS];
  logic [ADDR_WIDTH-1:0] wr_ptr_q [NUM_BANKS];
  logic [CNT_WIDTH-1:0]  count_q  [NUM_BANKS];
  logic [DATA_WIDTH-1:0] mem_q    [NUM_BANKS][DEPTH];

  logic [DATA_WIDTH-1:0]           fill_val [NUM_BANKS];
  logic [NUM_BANKS-1:0]            in_ready;
  logic [NUM_BANKS-1:0]            out_valid;
  logic [NUM_BANKS*DATA_WIDTH-1:0] out_data;
  logic [NUM_BANKS-1:0]            push;
  logic [NUM_BANKS-1:0]            pop;

  function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
    return (p == ADDR_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    in_ready  = '0;
    out_valid = '0;
    out_data  = '0;
    push      = '0;
    pop       = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (INC_INIT != 0) begin
        fill_val[b] = DATA_WIDTH'(INIT_VAL + b * DEPTH + 32'(fill_cnt_q));
      end else begin
        fill_val[b] = DATA_WIDTH'(INIT_VAL);
      end
      if (state_q == StReady) begin
        in_ready[b]  = count_q[b] != CNT_WIDTH'(DEPTH);
        out_valid[b] = count_q[b] != '0;
        if (out_valid[b]) begin
          out_data[b*DATA_WIDTH +: DATA_WIDTH] = mem_q[b][rd_ptr_q[b]];
        end
        // A reinit cycle discards any handshake that coincides with it.
        push[b] = bus.i__data_in_valid[b] & in_ready[b] & ~i__reinit;
        pop[b]  = bus.i__data_out_ready[b] & out_valid[b] & ~i__reinit;
      end
    end
  end

  assign bus.o__data_in_ready  = in_ready;
  assign bus.o__data_out_valid = out_valid;
  assign bus.o__data_out       = out_data;
  assign o__init_done          = init_done_q;

  always_ff @(posedge w__init_clk) begin
    if (reset) begin
      state_q     <= StInit;
      init_done_q <= 1'b0;
      fill_cnt_q  <= '0;
      for (int b = 0; b < NUM_BANKS; b++) begin
        rd_ptr_q[b] <= '0;
        wr_ptr_q[b] <= '0;
        count_q[b]  <= '0;
      end
    end else begin
      unique case (state_q)
        StInit: begin
          if (i__reinit) begin
            fill_cnt_q <= '0;
          end else if (fill_cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
            state_q     <= StReady;
            init_done_q <= 1'b1;
            fill_cnt_q  <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
              count_q[b] <= CNT_WIDTH'(DEPTH);
            end
          end else begin
            fill_cnt_q <= fill_cnt_q + 1'b1;
          end
        end
        StReady: begin
          if (i__reinit) begin
            state_q     <= StInit;
            init_done_q <= 1'b0;
            fill_cnt_q  <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
              rd_ptr_q[b] <= '0;
              wr_ptr_q[b] <= '0;
              count_q[b]  <= '0;
            end
          end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
              if (push[b]) wr_ptr_q[b] <= ptr_inc(wr_ptr_q[b]);
              if (pop[b])  rd_ptr_q[b] <= ptr_inc(rd_ptr_q[b]);
              if (push[b] && !pop[b]) begin
                count_q[b] <= count_q[b] + 1'b1;
              end else if (pop[b] && !push[b]) begin
                count_q[b] <= count_q[b] - 1'b1;
              end
            end
          end
        end
        default: state_q <= StInit;
      endcase
    end
  end

  // Storage is not reset; INIT overwrites every slot before it can be read.
  always_ff @(posedge w__init_clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (!reset) begin
        if (state_q == StInit) begin
          mem_q[b][fill_cnt_q] <= fill_val[b];
        end else if (push[b]) begin
          mem_q[b][wr_ptr_q[b]] <= bus.i__data_in[b*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

`ifdef FREE_LIST_INIT_OCCUPANCY_EN
  always_comb begin
    o__occupancy = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      o__occupancy[b*CNT_WIDTH +: CNT_WIDTH] = count_q[b];
    end
  end
`endif

endmodule
